// File: rtl/adam_axil_to_obi.sv
// -----------------------------------------------------------------------------
// adam_axil_to_obi
//
// AXI-Lite slave to OBI initiator bridge. Each accepted AXI-Lite read or write
// becomes exactly one OBI transaction. Only one transaction is in flight at a
// time. When both a read and a write are pending, they alternate fairly. A
// pause handshake lets ADAM power/clock management park the bridge while it
// is idle.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   pause_req / pause_ack  pause request; acknowledge when idle and paused
//   s_aw*, s_w*, s_b*      AXI-Lite write address / data / response channels
//   s_ar*, s_r*            AXI-Lite read address / data channels
//   obi_req/gnt/addr/we/be/wdata   OBI request phase
//   obi_rvalid/rready/rdata/err    OBI response phase
//
// The AXI ready outputs are the only combinational outputs. They depend only
// on state, the AXI valids and pause_req. There is no path from bready/rready.
// -----------------------------------------------------------------------------
module adam_axil_to_obi #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    pause_req,
    output logic                    pause_ack,

    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [2:0]              s_awprot,
    input  logic                    s_awvalid,
    output logic                    s_awready,

    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,

    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,

    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [2:0]              s_arprot,
    input  logic                    s_arvalid,
    output logic                    s_arready,

    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,

    output logic                    obi_req,
    input  logic                    obi_gnt,
    output logic [ADDR_WIDTH-1:0]   obi_addr,
    output logic                    obi_we,
    output logic [DATA_WIDTH/8-1:0] obi_be,
    output logic [DATA_WIDTH-1:0]   obi_wdata,
    input  logic                    obi_rvalid,
    output logic                    obi_rready,
    input  logic [DATA_WIDTH-1:0]   obi_rdata,
    input  logic                    obi_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        RSP    = 3'd2,
        B      = 3'd3,
        R      = 3'd4,
        PAUSED = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   be_q, be_d;
    logic                    we_q, we_d;
    logic                    last_was_write_q, last_was_write_d;
    logic [1:0]              resp_q, resp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic wr_elig, rd_elig, sel_read, sel_write;
    logic awready_c, wready_c, arready_c;

    // Protection bits carry no meaning for OBI targets.
    logic unused_prot;
    assign unused_prot = ^{s_awprot, s_arprot};

    assign wr_elig   = s_awvalid && s_wvalid;
    assign rd_elig   = s_arvalid;
    // Alternate on contention. Right after reset last_was_write=1, so a read wins.
    assign sel_read  = rd_elig && (!wr_elig || last_was_write_q);
    assign sel_write = wr_elig && !sel_read;

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        be_d             = be_q;
        we_d             = we_q;
        last_was_write_d = last_was_write_q;
        resp_d           = resp_q;
        rdata_d          = rdata_q;
        awready_c        = 1'b0;
        wready_c         = 1'b0;
        arready_c        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A pause request blocks any new accept in the same cycle.
                if (pause_req) begin
                    state_d = PAUSED;
                end else if (sel_read) begin
                    arready_c        = 1'b1;
                    addr_d           = s_araddr;
                    we_d             = 1'b0;
                    be_d             = '1;
                    last_was_write_d = 1'b0;
                    state_d          = REQ;
                end else if (sel_write) begin
                    awready_c        = 1'b1;
                    wready_c         = 1'b1;
                    addr_d           = s_awaddr;
                    wdata_d          = s_wdata;
                    be_d             = s_wstrb;
                    we_d             = 1'b1;
                    last_was_write_d = 1'b1;
                    state_d          = REQ;
                end
            end
            REQ: begin
                if (obi_gnt) state_d = RSP;
            end
            RSP: begin
                if (obi_rvalid) begin
                    resp_d = obi_err ? 2'b10 : 2'b00;
                    if (!we_q) rdata_d = obi_rdata;
                    state_d = we_q ? B : R;
                end
            end
            B: begin
                if (s_bready) state_d = IDLE;
            end
            R: begin
                if (s_rready) state_d = IDLE;
            end
            PAUSED: begin
                if (!pause_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            be_q             <= '0;
            we_q             <= 1'b0;
            last_was_write_q <= 1'b1;
            resp_q           <= 2'b00;
            rdata_q          <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            be_q             <= be_d;
            we_q             <= we_d;
            last_was_write_q <= last_was_write_d;
            resp_q           <= resp_d;
            rdata_q          <= rdata_d;
        end
    end

    assign s_awready  = awready_c;
    assign s_wready   = wready_c;
    assign s_arready  = arready_c;

    assign obi_req    = (state_q == REQ);
    assign obi_rready = (state_q == RSP);
    assign obi_addr   = addr_q;
    assign obi_we     = we_q;
    assign obi_be     = be_q;
    assign obi_wdata  = wdata_q;

    assign s_bvalid   = (state_q == B);
    assign s_bresp    = resp_q;
    assign s_rvalid   = (state_q == R);
    assign s_rresp    = resp_q;
    assign s_rdata    = rdata_q;

    assign pause_ack  = (state_q == PAUSED);

endmodule

// File: doc/adam_axil_to_obi.md
Name: adam_axil_to_obi

Overview:
- AXI-Lite slave to OBI initiator bridge: accepts AXI-Lite reads and writes and issues them as single OBI transactions to an OBI-native memory or peripheral.
- Complements the existing OBI-to-AXI-Lite master bridge. Used where an AXI-Lite fabric port must reach OBI-only targets, such as core-local memories.
- Processes one transaction at a time, with a pause handshake for ADAM power/clock management.

Parameters:
- ADDR_WIDTH, 32, address width of AXI-Lite and OBI.
- DATA_WIDTH, 32, data width. Must be a multiple of 8. STRB width = DATA_WIDTH/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- pause_req  in  1  pause request
- pause_ack  out  1  bridge idle and paused
- s_awaddr  in  ADDR_WIDTH  write address
- s_awprot  in  3  ignored
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  DATA_WIDTH/8  write strobes
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  ADDR_WIDTH  read address
- s_arprot  in  3  ignored
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- obi_req  out  1  OBI request
- obi_gnt  in  1  OBI grant
- obi_addr  out  ADDR_WIDTH  OBI address
- obi_we  out  1  OBI write enable
- obi_be  out  DATA_WIDTH/8  OBI byte enables
- obi_wdata  out  DATA_WIDTH  OBI write data
- obi_rvalid  in  1  OBI response valid
- obi_rready  out  1  OBI response ready
- obi_rdata  in  DATA_WIDTH  OBI read data
- obi_err  in  1  OBI error

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All ready/valid outputs, obi_req, obi_rready and pause_ack are 0.
  - s_bresp, s_rresp, s_rdata, obi_addr, obi_wdata, obi_be and obi_we are 0.
  - last_was_write is set to 1.
- Reset mid-transaction: the transaction is abandoned and no AXI response is issued. The OBI target shares rst_n.
- FSM states: IDLE, REQ, RSP, B, R, PAUSED.
- IDLE:
  - Write is eligible when s_awvalid && s_wvalid. AW and W are always accepted together.
  - Read is eligible when s_arvalid.
  - When both are eligible, serve the type opposite to last_was_write. On reset this means read first.
  - Accepting a write: s_awready=s_wready=1 for that one cycle (combinational in IDLE). Latch addr, wdata and wstrb. Set obi_we=1 and last_was_write=1. Go to REQ.
  - Accepting a read: s_arready=1 for that one cycle. Latch addr. Set obi_we=0, obi_be all ones and last_was_write=0. Go to REQ.
  - If pause_req=1 and no transaction is accepted in the same cycle, go to PAUSED. pause_req has priority over new eligible requests.
- REQ:
  - obi_req=1 with addr/we/be/wdata stable until obi_gnt=1. Go to RSP on the gnt cycle.
  - obi_req drops the cycle after the grant.
- RSP:
  - obi_rready=1.
  - On obi_rvalid: capture rdata (reads only). Set resp = obi_err ? 2'b10 (SLVERR) : 2'b00 (OKAY). Go to B for writes, R for reads.
- B: s_bvalid=1, s_bresp held until s_bready. Then go to IDLE.
- R: s_rvalid=1, s_rdata/s_rresp held until s_rready. Then go to IDLE.
- PAUSED:
  - pause_ack=1. All AXI ready outputs 0 and obi_req=0.
  - When pause_req=0, go to IDLE with pause_ack=0 from the next cycle.
- Pause during a transaction: the transaction completes, including the AXI response handshake. The bridge enters PAUSED from the following IDLE cycle.
- Latency: the AXI accept occurs in cycle 0, with obi_req=1 in cycle 1. With gnt in cycle 1 and rvalid in cycle 2, bvalid/rvalid=1 in cycle 3. Minimum turnaround is 4 cycles per transaction, since the next accept comes in the cycle after the B/R handshake.
- Outputs:
  - Response data and resp are registered.
  - AXI ready outputs are the only combinational outputs. They are functions of state, the valids and pause_req only, with no path from s_bready/s_rready.
- The s_awaddr and s_araddr low bits are passed through unmodified. s_awprot and s_arprot are ignored.

Test Plan:
- Write: s_awaddr=0x100, s_wdata=0xDEADBEEF, wstrb=0x3, gnt in the first REQ cycle, rvalid one cycle later -> obi_addr=0x100, we=1, be=0x3, wdata=0xDEADBEEF; bvalid with bresp=0 three cycles after accept.
- Read with gnt stall: araddr=0x200, gnt withheld 3 cycles, obi_rdata=0x12345678 -> obi_req held 4 cycles with stable addr; s_rdata=0x12345678, rresp=0, be=0xF.
- Simultaneous AW+W and AR valid from reset: read served first, then write; with both still valid, the next pick alternates again to read.
- Error and backpressure: write with obi_err=1 while s_bready=0 for 5 cycles -> bvalid and bresp=2'b10 held stable; no new AXI accept until the handshake completes.
- Pause: pause_req raised while in RSP -> response completes, pause_ack=1 afterwards, and s_arvalid=1 is not accepted. Dropping pause_req -> pause_ack=0 next cycle, then the read is accepted.
- Reset in REQ: rst_n=0 for one cycle while obi_req=1 -> next cycle obi_req=0, no bvalid/rvalid, and the bridge accepts a new read normally.
